// File: rtl/event_unpack_expand.sv
// Unpacks an MSB-first stream of SAMPLE_BITS-wide samples into OUT_LANES x LANE_BITS output words.
// Optional build macro UNPACK_FRAME_COUNT_EN adds frame_count_o / pad_count_o statistics ports.
module event_unpack_expand #(
    parameter int IN_WIDTH    = 64,
    parameter int SAMPLE_BITS = 12,
    parameter int LANE_BITS   = 16,
    parameter int OUT_LANES   = 32,
    parameter int SIGN_EXTEND = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IN_WIDTH-1:0]            s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic [LANE_BITS*OUT_LANES-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [LANE_BITS*OUT_LANES/8-1:0] m_axis_tkeep,
    output logic                           pad_o,
    output logic                           frag_o
`ifdef UNPACK_FRAME_COUNT_EN
    ,
    output logic [31:0]                    frame_count_o,
    output logic [15:0]                    pad_count_o
`endif
);

    localparam int P    = SAMPLE_BITS * OUT_LANES;
    localparam int ACCW = P + IN_WIDTH;
    localparam int CW   = $clog2(ACCW + 1);
    localparam int OW   = LANE_BITS * OUT_LANES;
    localparam logic [CW-1:0] P_C  = CW'(P);
    localparam logic [CW-1:0] IN_C = CW'(IN_WIDTH);
    localparam logic [CW-1:0] S_C  = CW'(SAMPLE_BITS);

    // Accumulator is left-aligned: the oldest bit sits at acc_q[ACCW-1]; bits below cnt_q are zero.
    logic [ACCW-1:0] acc_q, acc_d, acc_rem;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_rem;
    logic            pend_last_q, pend_last_d;
    logic [OW-1:0]   tdata_q, lanes;
    logic            tvalid_q, tlast_q, pad_q, frag_q;
    logic            accept, out_free, emit, empty_last, final_emit;

    assign s_axis_tready = !rst && !pend_last_q && (cnt_q < P_C);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign out_free      = !tvalid_q || m_axis_tready;
    assign emit          = out_free && ((cnt_q >= P_C) || (pend_last_q && (cnt_q != '0)));
    assign empty_last    = pend_last_q && (cnt_q == '0);
    assign final_emit    = emit && pend_last_q && (cnt_q <= P_C);

    always_comb begin
        acc_rem = acc_q;
        cnt_rem = cnt_q;
        if (emit) begin
            acc_rem = acc_q << P;
            cnt_rem = (cnt_q > P_C) ? (cnt_q - P_C) : '0;
        end
        acc_d = acc_rem;
        cnt_d = cnt_rem;
        // New word lands directly behind whatever survives this cycle's emission.
        if (accept) begin
            acc_d = acc_rem | (ACCW'(s_axis_tdata) << (P_C - cnt_rem));
            cnt_d = cnt_rem + IN_C;
        end
        pend_last_d = pend_last_q;
        if (accept && s_axis_tlast)
            pend_last_d = 1'b1;
        else if (empty_last || final_emit)
            pend_last_d = 1'b0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < OUT_LANES; gi++) begin : g_lane
            localparam logic [CW-1:0] END_C = CW'((gi + 1) * SAMPLE_BITS);
            logic [SAMPLE_BITS-1:0] smp;
            logic                   lane_ok;
            assign smp     = acc_q[ACCW-1-gi*SAMPLE_BITS -: SAMPLE_BITS];
            // A sample only counts once all of its bits are present; partial ones read as zero.
            assign lane_ok = (cnt_q >= END_C);
            if (LANE_BITS > SAMPLE_BITS) begin : g_ext
                logic ext;
                assign ext = (SIGN_EXTEND != 0) && smp[SAMPLE_BITS-1];
                assign lanes[gi*LANE_BITS +: LANE_BITS] =
                    lane_ok ? {{(LANE_BITS-SAMPLE_BITS){ext}}, smp} : '0;
            end else begin : g_noext
                assign lanes[gi*LANE_BITS +: LANE_BITS] = lane_ok ? smp : '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            pend_last_q <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            pad_q       <= 1'b0;
            frag_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pend_last_q <= pend_last_d;
            pad_q       <= 1'b0;
            frag_q      <= 1'b0;
            if (emit) begin
                tdata_q  <= lanes;
                tvalid_q <= 1'b1;
                tlast_q  <= final_emit;
                pad_q    <= final_emit && (cnt_q < P_C);
                frag_q   <= final_emit && ((cnt_q % S_C) != '0);
            end else if (m_axis_tready) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tkeep  = '1;
    assign pad_o         = pad_q;
    assign frag_o        = frag_q;

`ifdef UNPACK_FRAME_COUNT_EN
    logic [31:0] frame_count_q;
    logic [15:0] pad_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count_q <= '0;
            pad_count_q   <= '0;
        end else begin
            if (tvalid_q && m_axis_tready && tlast_q)
                frame_count_q <= frame_count_q + 32'd1;
            if (pad_q && (pad_count_q != 16'hFFFF))
                pad_count_q <= pad_count_q + 16'd1;
        end
    end

    assign frame_count_o = frame_count_q;
    assign pad_count_o   = pad_count_q;
`endif

endmodule

// File: tb/tb_event_unpack_expand.sv
// Scoreboard bench: three instances (default, sign-extending, 14-bit samples) with directed frames.
module tb_event_unpack_expand;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] s_tdata  [N];
    logic        s_tvalid [N];
    logic        s_tready [N];
    logic        s_tlast  [N];
    logic [511:0] m_tdata [N];
    logic        m_tvalid [N];
    logic        m_tready [N];
    logic        m_tlast  [N];
    logic [63:0] m_tkeep  [N];
    logic        pad      [N];
    logic        frag     [N];
`ifdef UNPACK_FRAME_COUNT_EN
    logic [31:0] fc [N];
    logic [15:0] pc [N];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            event_unpack_expand #(
                .IN_WIDTH   (64),
                .SAMPLE_BITS((gi == 2) ? 14 : 12),
                .LANE_BITS  (16),
                .OUT_LANES  (32),
                .SIGN_EXTEND((gi == 1) ? 1 : 0)
            ) u_dut (
                .clk          (clk),
                .rst          (rst),
                .s_axis_tdata (s_tdata[gi]),
                .s_axis_tvalid(s_tvalid[gi]),
                .s_axis_tready(s_tready[gi]),
                .s_axis_tlast (s_tlast[gi]),
                .m_axis_tdata (m_tdata[gi]),
                .m_axis_tvalid(m_tvalid[gi]),
                .m_axis_tready(m_tready[gi]),
                .m_axis_tlast (m_tlast[gi]),
                .m_axis_tkeep (m_tkeep[gi]),
                .pad_o        (pad[gi]),
                .frag_o       (frag[gi])
`ifdef UNPACK_FRAME_COUNT_EN
                ,
                .frame_count_o(fc[gi]),
                .pad_count_o  (pc[gi])
`endif
            );
        end
    endgenerate

    typedef struct packed {
        logic [511:0] data;
        logic         last;
        logic         pad;
        logic         frag;
    } exp_t;

    exp_t exp_q [N][$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt   [N];
    logic pad_seen  [N];
    logic frag_seen [N];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Stream of n samples, first sample at the MSB.
    function automatic logic [2047:0] pack(input int sbits, input int n, input int base, input int step);
        logic [2047:0] st;
        logic [15:0]   v;
        st = '0;
        for (int k = 0; k < n; k++) begin
            v = 16'(base + k * step);
            for (int b = 0; b < sbits; b++)
                st[2047 - k*sbits - b] = v[sbits-1-b];
        end
        return st;
    endfunction

    function automatic exp_t mk(input int sbits, input bit sext, input int nvalid, input int base,
                                input int step, input logic last, input logic pd, input logic fr);
        exp_t        e;
        logic [15:0] mask;
        logic [15:0] v;
        mask   = 16'((32'h1 << sbits) - 1);
        e.data = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nvalid) begin
                v = 16'(base + i * step) & mask;
                if (sext && v[sbits-1]) v = v | ~mask;
                e.data[16*i +: 16] = v;
            end
        end
        e.last = last;
        e.pad  = pd;
        e.frag = fr;
        return e;
    endfunction

    task automatic send(input int idx, input logic [63:0] d, input logic last);
        int n;
        n = 0;
        s_tdata[idx]  = d;
        s_tvalid[idx] = 1'b1;
        s_tlast[idx]  = last;
        forever begin
            @(negedge clk);
            if (s_tready[idx]) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout dut%0d actual=tready_low required=tready_high", idx);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid[idx] = 1'b0;
        s_tlast[idx]  = 1'b0;
    endtask

    task automatic send_frame(input int idx, input int sbits, input int nsamp, input int base,
                              input int step, input int nwords, input bit with_last);
        logic [2047:0] st;
        logic [63:0]   w;
        st = pack(sbits, nsamp, base, step);
        for (int j = 0; j < nwords; j++) begin
            w = st[2047 - 64*j -: 64];
            send(idx, w, with_last && (j == nwords - 1));
        end
    endtask

    task automatic drain();
        int n;
        int pending;
        n = 0;
        pending = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        while (pending != 0 && n < 500) begin
            @(posedge clk);
            n++;
            pending = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        end
        chk("drain_pending", 512'(pending), 512'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (s_tvalid[i] && s_tready[i]) acc_cnt[i]++;
                pad_seen[i]  = pad_seen[i] | pad[i];
                frag_seen[i] = frag_seen[i] | frag[i];
                if (m_tvalid[i] && !rst) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("unexpected_word_dut%0d", i), 512'(m_tvalid[i]), 512'(0));
                    end else begin
                        e = exp_q[i][0];
                        chk($sformatf("data_dut%0d", i), m_tdata[i], e.data);
                        chk($sformatf("tlast_dut%0d", i), 512'(m_tlast[i]), 512'(e.last));
                        if (m_tready[i]) begin
                            chk($sformatf("pad_dut%0d", i), 512'(pad_seen[i]), 512'(e.pad));
                            chk($sformatf("frag_dut%0d", i), 512'(frag_seen[i]), 512'(e.frag));
                            $display("dut%0d word lane0=%h lane31=%h tlast=%0b pad=%0b frag=%0b", i,
                                     m_tdata[i][15:0], m_tdata[i][511:496], m_tlast[i],
                                     pad_seen[i], frag_seen[i]);
                            pad_seen[i]  = 1'b0;
                            frag_seen[i] = 1'b0;
                            void'(exp_q[i].pop_front());
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            s_tdata[i]   = '0;
            s_tvalid[i]  = 1'b0;
            s_tlast[i]   = 1'b0;
            m_tready[i]  = 1'b1;
            acc_cnt[i]   = 0;
            pad_seen[i]  = 1'b0;
            frag_seen[i] = 1'b0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 512'(s_tready[0]), 512'(0));
        chk("rst_m_tvalid", 512'(m_tvalid[0]), 512'(0));
        chk("rst_m_tlast", 512'(m_tlast[0]), 512'(0));
        chk("rst_pad", 512'(pad[0]), 512'(0));
        chk("rst_frag", 512'(frag[0]), 512'(0));
        chk("tkeep", 512'(m_tkeep[0]), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("tready_after_rst", 512'(s_tready[0]), 512'(1));
        @(posedge clk);
        #1;

        // Samples 0..31 in six words, exact fill.
        exp_q[0].push_back(mk(12, 0, 32, 0, 1, 1'b1, 1'b0, 1'b0));
        send_frame(0, 12, 32, 0, 1, 6, 1'b1);

        // All-ones samples, zero-fill vs sign-extend.
        exp_q[0].push_back(mk(12, 0, 32, 4095, 0, 1'b1, 1'b0, 1'b0));
        send_frame(0, 12, 32, 4095, 0, 6, 1'b1);
        exp_q[1].push_back(mk(12, 1, 32, 4095, 0, 1'b1, 1'b0, 1'b0));
        send_frame(1, 12, 32, 4095, 0, 6, 1'b1);

        // Short frame: 16 samples then zero padding.
        exp_q[0].push_back(mk(12, 0, 16, 'h100, 1, 1'b1, 1'b1, 1'b0));
        send_frame(0, 12, 16, 'h100, 1, 3, 1'b1);

        // 14-bit samples, single word: four whole samples plus an 8-bit fragment.
        exp_q[2].push_back(mk(14, 0, 4, 'h1234, 'h101, 1'b1, 1'b1, 1'b1));
        send_frame(2, 14, 5, 'h1234, 'h101, 1, 1'b1);
        drain();

        // Output stalled for 20 cycles while input keeps coming.
        m_tready[0] = 1'b0;
        acc_cnt[0]  = 0;
        exp_q[0].push_back(mk(12, 0, 32, 0, 1, 1'b0, 1'b0, 1'b0));
        exp_q[0].push_back(mk(12, 0, 32, 32, 1, 1'b0, 1'b0, 1'b0));
        exp_q[0].push_back(mk(12, 0, 32, 64, 1, 1'b1, 1'b0, 1'b0));
        fork
            send_frame(0, 12, 96, 0, 1, 18, 1'b1);
            begin
                repeat (20) @(posedge clk);
                @(negedge clk);
                chk("stall_accepts", 512'(acc_cnt[0]), 512'(12));
                chk("stall_s_tready", 512'(s_tready[0]), 512'(0));
                @(posedge clk);
                #1 m_tready[0] = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a frame, then a clean frame.
        send_frame(0, 12, 24, 'h700, 1, 3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_m_tvalid", 512'(m_tvalid[0]), 512'(0));
        chk("midrst_s_tready", 512'(s_tready[0]), 512'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q[0].push_back(mk(12, 0, 32, 'h200, 3, 1'b1, 1'b0, 1'b0));
        send_frame(0, 12, 32, 'h200, 3, 6, 1'b1);
        drain();

        for (int i = 0; i < N; i++)
            chk($sformatf("queue_empty_dut%0d", i), 512'(exp_q[i].size()), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
